// File: rtl/svi_tape_player.sv
// Cassette FSK playback: leader, then per byte a '0' start bit, 8 data bits LSB first, two '1' stop bits.
// Latency: play_i rise to tape_o high is 1 clk_i plus 1 ce_i tick; bits run back to back with no gap.
// Backpressure: 1-deep holding register, byte_ready_o = busy & ~full; underrun emits filler '1' bits.
module svi_tape_player #(
    parameter int HALF0       = 4474,
    parameter int HALF1       = 2237,
    parameter int LEADER_BITS = 4096,
    parameter int CW          = 16
) (
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic       ce_i,
    input  logic       play_i,
    input  logic [7:0] byte_i,
    input  logic       byte_valid_i,
    output logic       byte_ready_o,
    input  logic       eof_i,
    output logic       tape_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       filler_o
);
    typedef enum logic [2:0] {
        S_IDLE, S_LEADER, S_START, S_DATA, S_STOP, S_FILL, S_DONE
    } state_t;

    localparam logic [CW-1:0] H0_LAST     = CW'(HALF0 - 1);
    localparam logic [CW-1:0] H1_LAST     = CW'(HALF1 - 1);
    localparam int            BW          = ($clog2(LEADER_BITS + 1) > 3) ? $clog2(LEADER_BITS + 1) : 3;
    localparam logic [BW-1:0] LEADER_LAST = BW'(LEADER_BITS - 1);
    localparam logic [BW-1:0] DATA_LAST   = BW'(7);
    localparam logic [BW-1:0] STOP_LAST   = BW'(1);

    state_t        state;
    logic [7:0]    hold;
    logic          full;
    logic [7:0]    shreg;
    logic [BW-1:0] bcnt;
    logic [CW-1:0] hcnt;
    logic [1:0]    hidx;
    logic          cur_bit;
    logic          active;

    logic [CW-1:0] half_last;
    logic          half_end;
    logic          bit_end;
    logic          at_boundary;
    state_t        nstate;
    logic          start_bit;
    logic          nbit;
    logic          fill_start;

    assign busy_o       = (state != S_IDLE) && (state != S_DONE);
    assign byte_ready_o = busy_o && !full;

    always_comb begin
        half_last   = cur_bit ? H1_LAST : H0_LAST;
        half_end    = ce_i && active && (hcnt == half_last);
        bit_end     = half_end && (hidx == (cur_bit ? 2'd3 : 2'd1));
        at_boundary = bit_end && (((state == S_LEADER) && (bcnt == LEADER_LAST)) ||
                                  ((state == S_STOP) && (bcnt == STOP_LAST)) ||
                                  (state == S_FILL));
    end

    // Next-bit selection; a new bit always starts on the tick that ends the previous one.
    always_comb begin
        nstate     = state;
        start_bit  = 1'b0;
        nbit       = 1'b1;
        fill_start = 1'b0;
        if (at_boundary) begin
            if (full) begin
                nstate    = S_START;
                start_bit = 1'b1;
                nbit      = 1'b0;
            end else if (eof_i) begin
                nstate = S_DONE;
            end else begin
                nstate     = S_FILL;
                start_bit  = 1'b1;
                fill_start = 1'b1;
            end
        end else begin
            case (state)
                S_LEADER: start_bit = (ce_i && !active) || bit_end;
                S_START: begin
                    if (bit_end) begin
                        nstate    = S_DATA;
                        start_bit = 1'b1;
                        nbit      = shreg[0];
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        start_bit = 1'b1;
                        if (bcnt == DATA_LAST) nstate = S_STOP;
                        else                   nbit   = shreg[1];
                    end
                end
                S_STOP:  start_bit = bit_end;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state    <= S_IDLE;
            hold     <= '0;
            full     <= 1'b0;
            shreg    <= '0;
            bcnt     <= '0;
            hcnt     <= '0;
            hidx     <= '0;
            cur_bit  <= 1'b0;
            active   <= 1'b0;
            tape_o   <= 1'b0;
            done_o   <= 1'b0;
            filler_o <= 1'b0;
        end else if (!play_i) begin
            state    <= S_IDLE;
            full     <= 1'b0;
            bcnt     <= '0;
            hcnt     <= '0;
            hidx     <= '0;
            active   <= 1'b0;
            tape_o   <= 1'b0;
            done_o   <= 1'b0;
            filler_o <= 1'b0;
        end else begin
            filler_o <= fill_start;
            if (byte_valid_i && byte_ready_o) begin
                hold <= byte_i;
                full <= 1'b1;
            end
            if (state == S_IDLE) begin
                state <= S_LEADER;
                bcnt  <= '0;
            end else begin
                state <= nstate;
                if ((nstate == S_START) && (state != S_START)) begin
                    shreg <= hold;
                    full  <= 1'b0;
                end
                if ((state == S_DATA) && bit_end)
                    shreg <= shreg >> 1;
                if (bit_end)
                    bcnt <= (nstate == state) ? bcnt + BW'(1) : '0;
                // Every bit opens high; halves then alternate until the bit closes low.
                if (start_bit) begin
                    tape_o  <= 1'b1;
                    hcnt    <= '0;
                    hidx    <= '0;
                    cur_bit <= nbit;
                    active  <= 1'b1;
                end else if (nstate == S_DONE) begin
                    tape_o <= 1'b0;
                    active <= 1'b0;
                    done_o <= 1'b1;
                end else if (half_end) begin
                    hcnt   <= '0;
                    hidx   <= hidx + 2'd1;
                    tape_o <= ~tape_o;
                end else if (ce_i && active) begin
                    hcnt <= hcnt + CW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_svi_tape_player.sv
// Bench for svi_tape_player with short timing parameters: vector table, corner sequences, random vs model.
module tb_svi_tape_player;
    localparam int HALF0       = 4;
    localparam int HALF1       = 2;
    localparam int LEADER_BITS = 3;
    localparam int BITLEN      = 8;

    logic       clk;
    logic       rst_n;
    logic       ce;
    logic       play;
    logic [7:0] byte_d;
    logic       valid;
    logic       ready;
    logic       eof;
    logic       tape;
    logic       busy;
    logic       done;
    logic       filler;

    svi_tape_player #(
        .HALF0(HALF0), .HALF1(HALF1), .LEADER_BITS(LEADER_BITS), .CW(4)
    ) dut (
        .clk_i(clk), .reset_n_i(rst_n), .ce_i(ce), .play_i(play),
        .byte_i(byte_d), .byte_valid_i(valid), .byte_ready_o(ready), .eof_i(eof),
        .tape_o(tape), .busy_o(busy), .done_o(done), .filler_o(filler)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;
    int ce_mode  = 0;
    int ce_phase = 0;

    logic cap_t[$], cap_f[$], cap_r[$];
    logic exp_t[$], exp_f[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Drive ce for the coming edge, then step to the next sampling point.
    task automatic cyc();
        ce = (ce_mode == 0) ? 1'b1 : ((ce_phase % 4) == 0);
        ce_phase++;
        @(negedge clk);
    endtask

    task automatic clear_q();
        cap_t.delete(); cap_f.delete(); cap_r.delete();
        exp_t.delete(); exp_f.delete();
    endtask

    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            cap_t.push_back(tape);
            cap_f.push_back(filler);
            cap_r.push_back(ready);
            cyc();
        end
    endtask

    task automatic exp_bit(input logic b, input int rep, input logic fill);
        for (int p = 0; p < BITLEN; p++) begin
            int   h;
            logic lvl;
            h   = b ? HALF1 : HALF0;
            lvl = ((p / h) % 2) == 0;
            for (int r = 0; r < rep; r++) begin
                exp_t.push_back(lvl);
                exp_f.push_back(fill && (p == 0) && (r == 0));
            end
        end
    endtask

    task automatic exp_low(input int n);
        for (int i = 0; i < n; i++) begin
            exp_t.push_back(1'b0);
            exp_f.push_back(1'b0);
        end
    endtask

    task automatic exp_leader(input int rep);
        for (int i = 0; i < LEADER_BITS; i++) exp_bit(1'b1, rep, 1'b0);
    endtask

    task automatic exp_frame(input logic [10:0] f, input int rep);
        for (int i = 0; i < 11; i++) exp_bit(f[i], rep, 1'b0);
    endtask

    task automatic compare_seqs(input string name);
        int bt, bf;
        bt = -1;
        bf = -1;
        for (int i = 0; i < exp_t.size(); i++) begin
            if (bt < 0 && (i >= cap_t.size() || cap_t[i] !== exp_t[i])) bt = i;
            if (bf < 0 && (i >= cap_f.size() || cap_f[i] !== exp_f[i])) bf = i;
        end
        n_checks += 2;
        if (bt >= 0) begin
            n_fail++;
            $display("FAIL %s_tape: sample %0d got %0b expected %0b", name, bt,
                     (bt < cap_t.size()) ? cap_t[bt] : 1'bx, exp_t[bt]);
        end
        if (bf >= 0) begin
            n_fail++;
            $display("FAIL %s_filler: sample %0d got %0b expected %0b", name, bf,
                     (bf < cap_f.size()) ? cap_f[bf] : 1'bx, exp_f[bf]);
        end
    endtask

    // Reference model: a queue of pending bits plus a tick position inside the current bit.
    logic       m_on, m_active, m_done, m_full, m_fill, m_cur;
    logic [7:0] m_hold;
    int         m_pos;
    int         mq[$];

    function automatic logic m_tape();
        return m_active && (((m_pos / (m_cur ? HALF1 : HALF0)) % 2) == 0);
    endfunction
    function automatic logic m_busy();
        return m_on && !m_done;
    endfunction
    function automatic logic m_ready();
        return m_on && !m_done && !m_full;
    endfunction

    task automatic model_step(input logic p, input logic v, input logic [7:0] b,
                              input logic e, input logic c);
        logic old_full, rdy;
        if (!p) begin
            m_on = 0; m_active = 0; m_done = 0; m_full = 0; m_fill = 0; m_pos = 0;
            mq.delete();
        end else begin
            m_fill = 0;
            if (!m_on) begin
                m_on = 1;
            end else if (!m_done) begin
                old_full = m_full;
                rdy      = !m_full;
                if (c) begin
                    if (!m_active) begin
                        m_active = 1;
                        for (int i = 0; i < LEADER_BITS; i++) mq.push_back(1);
                        m_cur = mq.pop_front();
                        m_pos = 0;
                    end else begin
                        m_pos++;
                        if (m_pos == BITLEN) begin
                            if (mq.size() == 0) begin
                                if (old_full) begin
                                    mq.push_back(0);
                                    for (int i = 0; i < 8; i++) mq.push_back(int'(m_hold[i]));
                                    mq.push_back(1);
                                    mq.push_back(1);
                                    m_full = 0;
                                end else if (e) begin
                                    m_done   = 1;
                                    m_active = 0;
                                end else begin
                                    mq.push_back(1);
                                    m_fill = 1;
                                end
                            end
                            if (!m_done) begin
                                m_cur = mq.pop_front();
                                m_pos = 0;
                            end
                        end
                    end
                end
                if (rdy && v) begin
                    m_full = 1;
                    m_hold = b;
                end
            end
        end
    endtask

    typedef struct {
        logic [7:0]  b;
        logic        eof_after;
        logic [10:0] frame;
        logic        exp_done;
    } row_t;
    row_t rows[4];

    initial begin
        int k, src_left;
        logic acc;

        rows[0] = '{8'hA5, 1'b0, 11'b111_0100_1010, 1'b0};
        rows[1] = '{8'h3C, 1'b1, 11'b110_0111_1000, 1'b1};
        rows[2] = '{8'h81, 1'b1, 11'b111_0000_0010, 1'b1};
        rows[3] = '{8'h00, 1'b0, 11'b110_0000_0000, 1'b0};

        rst_n = 0; play = 1; valid = 1; byte_d = 8'hFF; eof = 0; ce = 1;
        repeat (3) @(negedge clk);
        check("rst_tape", tape, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", ready, 0);
        check("rst_done", done, 0);
        check("rst_filler", filler, 0);
        play = 0; valid = 0; rst_n = 1;
        repeat (3) cyc();
        check("idle_tape", tape, 0);
        check("idle_ready", ready, 0);

        for (int i = 0; i < 4; i++) begin
            play = 0; valid = 0; eof = 0; ce_mode = 0;
            cyc(); cyc();
            byte_d = rows[i].b; valid = 1; play = 1;
            cyc();
            check($sformatf("row%0d_ready_open", i), ready, 1);
            cyc();
            check($sformatf("row%0d_accept", i), ready, 0);
            valid = 0; eof = rows[i].eof_after;
            clear_q();
            exp_leader(1);
            exp_frame(rows[i].frame, 1);
            if (rows[i].exp_done) exp_low(8);
            else exp_bit(1'b1, 1, 1'b1);
            capture(exp_t.size());
            compare_seqs($sformatf("row%0d", i));
            check($sformatf("row%0d_ready_reopen", i), {cap_r[23], cap_r[24]}, 2'b01);
            check($sformatf("row%0d_done", i), done, rows[i].exp_done);
            check($sformatf("row%0d_busy", i), busy, !rows[i].exp_done);
            if (rows[i].exp_done) begin
                play = 0;
                cyc();
                check($sformatf("row%0d_done_clear", i), done, 0);
            end
        end

        // Back-to-back frames with the second byte offered mid-DATA.
        play = 0; valid = 0; eof = 0;
        cyc(); cyc();
        byte_d = 8'h00; valid = 1; play = 1;
        cyc(); cyc();
        valid = 0;
        clear_q();
        exp_leader(1);
        exp_frame(11'b110_0000_0000, 1);
        exp_frame(11'b111_1111_1110, 1);
        exp_low(8);
        capture(40);
        byte_d = 8'hFF; valid = 1;
        capture(1);
        valid = 0; eof = 1;
        capture(exp_t.size() - 41);
        compare_seqs("b2b");
        check("b2b_done", done, 1);

        // Abort mid-DATA with a second byte parked in the holding register.
        play = 0; valid = 0; eof = 0;
        cyc(); cyc();
        byte_d = 8'h5A; valid = 1; play = 1;
        cyc(); cyc();
        valid = 0;
        repeat (40) cyc();
        byte_d = 8'h33; valid = 1;
        cyc();
        valid = 0;
        check("abort_hold_full", ready, 0);
        repeat (10) cyc();
        check("abort_pre_tape", tape, 1);
        play = 0;
        cyc();
        check("abort_tape", tape, 0);
        check("abort_busy", busy, 0);
        check("abort_ready", ready, 0);
        cyc();
        play = 1;
        cyc(); cyc();
        clear_q();
        exp_leader(1);
        exp_bit(1'b1, 1, 1'b1);
        exp_bit(1'b1, 1, 1'b1);
        capture(exp_t.size());
        compare_seqs("abort_restart");

        // ce_i one clock in four: waveform stretched 4x.
        play = 0; valid = 0; eof = 0;
        cyc(); cyc();
        ce_mode = 1; ce_phase = 0;
        byte_d = 8'hA5; valid = 1; play = 1;
        k = 0;
        while (tape !== 1'b1 && k < 12) begin
            cyc();
            k++;
            if (k == 2) valid = 0;
        end
        valid = 0;
        check("throttle_latency", k, 5);
        clear_q();
        exp_leader(4);
        exp_frame(11'b111_0100_1010, 4);
        exp_bit(1'b1, 4, 1'b1);
        capture(exp_t.size());
        compare_seqs("throttle");
        ce_mode = 0;

        // Randomised traffic against the reference model.
        play = 0; valid = 0; eof = 0; ce = 1; src_left = 0;
        model_step(play, valid, byte_d, eof, ce);
        @(negedge clk);
        for (int c = 0; c < 5000; c++) begin
            check($sformatf("rand_c%0d_tape_busy_ready_done_filler", c),
                  {tape, busy, ready, done, filler},
                  {m_tape(), m_busy(), m_ready(), m_done, m_fill});
            if (!play) begin
                valid = 0; eof = 0;
                if ($urandom_range(0, 3) == 0) begin
                    play     = 1;
                    src_left = $urandom_range(0, 4);
                end
            end else if ($urandom_range(0, 699) == 0) begin
                play = 0; valid = 0; eof = 0;
            end else begin
                if (!valid && src_left > 0 && $urandom_range(0, 3) == 0) begin
                    valid  = 1;
                    byte_d = 8'($urandom);
                end
                if (src_left == 0 && $urandom_range(0, 199) == 0) eof = 1;
            end
            ce  = ($urandom_range(0, 9) < 7);
            acc = valid && m_ready();
            model_step(play, valid, byte_d, eof, ce);
            @(negedge clk);
            if (acc) begin
                src_left--;
                valid = 0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/svi_tape_player.md
Name: svi_tape_player

Overview:
- Cassette playback generator for the SVI-328 core. It is the transmit end of the tape path that the console samples on its tape-in input.
- It takes a byte stream (from a CAS image in SDRAM, fetched by the loader) over a valid/ready handshake.
- It emits an FSK square wave on tape_o, framed as leader, start bit, 8 data bits, stop bits.
- tape_o drives the console tape input in place of the UART pin while playback is active.

Parameters:
- HALF0, 4474: ce_i ticks per half-period of a '0' bit (1200 Hz at 10.738635 MHz ce).
- HALF1, 2237: ce_i ticks per half-period of a '1' bit (2400 Hz).
- LEADER_BITS, 4096: number of '1' bits emitted before the first byte.
- CW, 16: half-period counter width; must hold max(HALF0,HALF1)-1.

Ports:
- clk_i  in  1  system clock (clk_sys)
- reset_n_i  in  1  asynchronous, active-low reset
- ce_i  in  1  timing tick (ce_10m7); all waveform timing counts ce_i ticks
- play_i  in  1  playback enable (cassette motor on); level-sensitive
- byte_i  in  8  next data byte
- byte_valid_i  in  1  byte_i valid
- byte_ready_o  out  1  holding register empty; transfer when valid & ready on a clk_i edge
- eof_i  in  1  source has no more bytes
- tape_o  out  1  FSK tape level
- busy_o  out  1  sequencer not IDLE/DONE
- done_o  out  1  stream finished; held until play_i falls
- filler_o  out  1  one-clk pulse for each filler '1' bit emitted (source underrun)

Behaviour:
- Reset: all outputs 0, state IDLE, holding register empty, counters 0.
- Bit generator:
  - Each bit starts on a ce_i tick with tape_o set to 1.
  - tape_o toggles every HALF0 ticks for a '0' (2 halves) or every HALF1 ticks for a '1' (4 halves).
  - Every bit ends low. Bit time = 2*HALF0 = 4*HALF1 ticks.
  - bit_end is an internal strobe on the tick that completes the last half-period.
  - The next bit starts on the same tick, so there is no gap.
- Holding register (1 deep):
  - byte_ready_o = busy_o & ~full.
  - On valid & ready the byte is latched and full=1. Ready drops on the next clk_i.
  - Accepted in any busy state, including mid-bit.
- States:
  - IDLE: tape_o=0. On play_i=1 go to LEADER; the first bit starts on the first ce_i tick in LEADER.
  - LEADER: emit LEADER_BITS '1' bits, then take the bit-boundary decision.
  - START: emit '0', load shift reg from holding register, full=0 at entry; then DATA.
  - DATA: 8 bits, LSB first; then STOP.
  - STOP: 2 '1' bits; then the bit-boundary decision.
  - FILL: one '1' bit with a filler_o pulse at bit start; then the bit-boundary decision.
  - DONE: tape_o=0, done_o=1, busy_o=0, byte_ready_o=0.
- Bit-boundary decision, evaluated at bit_end of the last leader bit, of the second stop bit, and of a filler bit:
  - full → START.
  - else eof_i=1 → DONE.
  - else → FILL.
  - full wins over eof_i when both are set.
- play_i=0 in any state: next clk_i goes to IDLE, tape_o=0, holding register cleared, done_o cleared, mid-bit abort allowed.
- A new play_i rise restarts with the full leader.
- ce_i=0: all timing is frozen, but the handshake still operates.
- Latency:
  - play_i rise → tape_o=1 at most 1 clk_i + 1 ce_i tick later.
  - Byte accepted during the stop bits is transmitted with no filler.

Test Plan (HALF0=4, HALF1=2, LEADER_BITS=3, ce_i=1 unless stated):
- Reset/idle: hold reset_n_i=0 with play_i=1 → all outputs 0. Release with play_i=0 → tape_o stays 0 and byte_ready_o=0.
- Leader: play_i rise, no data, eof_i=0 →
  - 3 bits of pattern 11001100 (24 clk).
  - Then FILL bits each 11001100, filler_o pulsing every 8 clk.
  - byte_ready_o=1 throughout.
- Byte frame: byte 0xA5 presented valid from the start →
  - Accepted on the first clk; ready=0 until START.
  - After the leader, 11 bits 0,1,0,1,0,0,1,0,1,1,1.
  - '0' = 11110000, '1' = 11001100; 88 clk; no filler_o.
- Back-to-back: bytes 0x00 then 0xFF, second valid during the first's DATA → no FILL between frames, second start bit begins immediately after the second stop bit.
- End of stream: after the last byte, eof_i=1 and valid=0 → DONE at the stop-bit end, tape_o=0, done_o=1. play_i fall clears done_o.
- Abort/throttle:
  - play_i=0 mid-DATA → tape_o=0 next clk, busy_o=0, latched byte discarded.
  - Separately, ce_i=1 one clk in 4 → waveform stretched exactly 4x.
